encoder_scan: RTL and testbench
===============================

ENCODER_SCAN -- requirements
Module: encoder_scan

Interface
REQ-001 SHALL have parameter N, default 8: request vector width, N >= 2.
REQ-002 SHALL have localparam W = clog2(N): index width (3 at N=8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i, input, N bits: multi-hot request vector.
REQ-006 SHALL have port in_valid, input, 1 bit: i is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept i.
REQ-008 SHALL have port y, output, W bits: index of the current set bit.
REQ-009 SHALL have port out_valid, output, 1 bit: y is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts y.
REQ-011 SHALL have port out_last, output, 1 bit: y is the final index of the captured vector.
REQ-012 SHALL have port zero_flag, output, 1 bit: one-cycle pulse when an all-zero vector is accepted.

Function
REQ-013 SHALL implement two states, IDLE and SCAN; in_ready = 1 only in IDLE; out_valid = 1 only in SCAN.
REQ-014 SHALL, in IDLE on in_valid=1 with i != 0, capture i into pend register and enter SCAN next cycle; out_valid high one cycle after acceptance.
REQ-015 SHALL, in IDLE on in_valid=1 with i == 0, stay in IDLE, pulse zero_flag high for exactly the next cycle, produce no output beat.
REQ-016 SHALL drive y = index of lowest set bit of pend (LSB first); y is a pure function of registered pend.
REQ-017 SHALL drive out_last = 1 when pend has exactly one bit set.
REQ-018 SHALL, on out_valid && out_ready, clear bit y of pend; if out_last, return to IDLE next cycle.
REQ-019 SHALL hold y, out_last and pend stable while out_valid=1 and out_ready=0.
REQ-020 SHALL ignore i and in_valid while in SCAN (no capture, no zero_flag).
REQ-021 SHALL sustain one beat per cycle with out_ready held high: k set bits -> k consecutive beats.
REQ-022 SHALL, after the last beat, assert in_ready in the next cycle; no overlap of capture and final beat.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, pend 0, y 0, out_valid 0, out_last 0, zero_flag 0, in_ready 1, independent of clk.
REQ-024 SHALL, on reset asserted mid-SCAN, discard remaining pending bits; first acceptance possible on first rising clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL support macro ENCODER_POPCOUNT_EN: when defined, add output out_count (W+1 bits) = number of set bits in i, registered at capture, held until next capture, 0 on reset and 0 after a zero-vector capture.
REQ-026 SHALL, without ENCODER_POPCOUNT_EN, omit out_count port and its logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place state enum (IDLE, SCAN) and clog2 helper function in shared package encoder_pkg.
REQ-028 SHALL instantiate sub-module lsb_find (parameter N; combinational: N-bit vector in -> W-bit lowest-set index plus any-set flag) for y generation.

Verification
REQ-029 SHALL verify N=8, i=8'b00000100 accepted -> one cycle later out_valid=1, y=3'd2, out_last=1; in_ready=1 cycle after handshake.
REQ-030 SHALL verify N=8, i=8'b10010010, out_ready=1 -> y=1,4,7 on three consecutive cycles, out_last only with y=7.
REQ-031 SHALL verify i=8'b00100001 with out_ready=0 for 3 cycles -> y=0 held stable 3 cycles, then y=5 after ready.
REQ-032 SHALL verify i=8'h00 accepted -> zero_flag high exactly one cycle, out_valid stays 0, in_ready stays 1.
REQ-033 SHALL verify rst_n pulled low mid-scan of 8'hFF after y=2 -> out_valid 0 immediately; after release, new i=8'h80 yields single beat y=7.
REQ-034 SHALL verify N=16, i=16'hFFFF, ENCODER_POPCOUNT_EN defined -> out_count=16, y=0..15 on 16 consecutive cycles, in_valid pulses during SCAN ignored.

Source files
------------

// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder_pkg
// Description : Shared types and helpers for the encoder_scan block: the
//               two-state scan FSM encoding and a constant clog2 function.
// Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

  // Scan controller states: IDLE accepts a request vector, SCAN emits indices.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_scan_lsb_find.sv
`default_nettype none
// ============================================================================
// Module      : lsb_find
// Description : Combinational lowest-set-bit finder. Returns the index of the
//               least significant set bit of vec_i and a flag that any bit
//               is set. Index is 0 when the vector is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_find
  import encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Scan from MSB down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec_i[k]) idx_o = k[W-1:0];
    end
  end

  assign any_o = |vec_i;

endmodule
`default_nettype wire

// File: rtl/encoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : encoder_scan
// Description : Captures a multi-hot request vector and emits the index of
//               each set bit, LSB first, one per accepted output beat, with
//               a last-beat marker. An all-zero vector produces a one-cycle
//               zero_flag pulse instead of any beats.
//               Optional feature macro ENCODER_POPCOUNT_EN adds out_count,
//               the number of set bits in the most recently captured vector.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_scan
  import encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         zero_flag
`ifdef ENCODER_POPCOUNT_EN
  ,
  output logic [W:0]   out_count
`endif
);

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic           zero_flag_q, zero_flag_d;
  logic [W-1:0]   w_idx;
  logic           w_any;
  logic           w_last;
  logic [N-1:0]   w_pend_drop;

  lsb_find #(.N(N)) u_lsb_find (
    .vec_i (pend_q),
    .idx_o (w_idx),
    .any_o (w_any)
  );

  // Clearing the lowest set bit is the same as clearing bit y.
  assign w_pend_drop = pend_q & (pend_q - 1'b1);
  assign w_last      = w_any && (w_pend_drop == '0);

`ifdef ENCODER_POPCOUNT_EN
  logic [W:0] count_q, count_d;
  logic [W:0] w_popcnt;

  // Population count of the incoming request vector.
  always_comb begin
    w_popcnt = '0;
    for (int k = 0; k < N; k++) begin
      w_popcnt = w_popcnt + (W+1)'(i[k]);
    end
  end
`endif

  // Next-state logic for the IDLE/SCAN controller.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    zero_flag_d = 1'b0;
`ifdef ENCODER_POPCOUNT_EN
    count_d     = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (|i) begin
            pend_d  = i;
            state_d = SCAN;
`ifdef ENCODER_POPCOUNT_EN
            count_d = w_popcnt;
`endif
          end else begin
            zero_flag_d = 1'b1;
`ifdef ENCODER_POPCOUNT_EN
            count_d     = '0;
`endif
          end
        end
      end
      SCAN: begin
        // out_valid is always high in SCAN, so out_ready alone is the handshake.
        if (out_ready) begin
          pend_d = w_pend_drop;
          if (w_last) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      zero_flag_q <= 1'b0;
`ifdef ENCODER_POPCOUNT_EN
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      zero_flag_q <= zero_flag_d;
`ifdef ENCODER_POPCOUNT_EN
      count_q     <= count_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SCAN);
  assign y         = w_idx;
  assign out_last  = w_last;
  assign zero_flag = zero_flag_q;
`ifdef ENCODER_POPCOUNT_EN
  assign out_count = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_encoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_scan
// Description : Directed self-checking bench for encoder_scan at N=8 and a
//               second instance at N=16 (out_count checked when
//               ENCODER_POPCOUNT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_scan;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i8;
  logic        iv8, ordy8;
  logic        ir8, ov8, last8, zf8;
  logic [2:0]  y8;
  logic [15:0] i16;
  logic        iv16, ordy16;
  logic        ir16, ov16, last16, zf16;
  logic [3:0]  y16;
`ifdef ENCODER_POPCOUNT_EN
  logic [3:0]  cnt8;
  logic [4:0]  cnt16;
`endif

  int vectors;
  int errors;

  encoder_scan #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i8),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .y         (y8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .out_last  (last8),
    .zero_flag (zf8)
`ifdef ENCODER_POPCOUNT_EN
    ,
    .out_count (cnt8)
`endif
  );

  encoder_scan #(.N(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i16),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .y         (y16),
    .out_valid (ov16),
    .out_ready (ordy16),
    .out_last  (last16),
    .zero_flag (zf16)
`ifdef ENCODER_POPCOUNT_EN
    ,
    .out_count (cnt16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || y8 !== 3'd0 || last8 !== 1'b0 || zf8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: ir=%b ov=%b y=%0d last=%b zf=%b, want 1 0 0 0 0", ir8, ov8, y8, last8, zf8);
    end
    vectors++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || zf16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: ir=%b ov=%b zf=%b, want 1 0 0", ir16, ov16, zf16);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    i8 = 8'b0000_0100; iv8 = 1'b1; ordy8 = 1'b0;
    tick();
    iv8 = 1'b0; i8 = 8'h00;
    vectors++;
    if (ov8 !== 1'b1 || y8 !== 3'd2 || last8 !== 1'b1 || ir8 !== 1'b0) begin
      errors++;
      $display("FAIL single_beat: ov=%b y=%0d last=%b ir=%b, want 1 2 1 0", ov8, y8, last8, ir8);
    end
`ifdef ENCODER_POPCOUNT_EN
    vectors++;
    if (cnt8 !== 4'd1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", cnt8);
    end
`endif
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
    vectors++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL single_return: ir=%b ov=%b, want 1 0", ir8, ov8);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_y [3];
    exp_y[0] = 3'd1; exp_y[1] = 3'd4; exp_y[2] = 3'd7;
    i8 = 8'b1001_0010; iv8 = 1'b1; ordy8 = 1'b1;
    tick();
    iv8 = 1'b0; i8 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (ov8 !== 1'b1 || y8 !== exp_y[k] || last8 !== (k == 2)) begin
        errors++;
        $display("FAIL b2b_beat%0d: ov=%b y=%0d last=%b, want 1 %0d %b", k, ov8, y8, last8, exp_y[k], (k == 2));
      end
      tick();
    end
    ordy8 = 1'b0;
    vectors++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: ov=%b ir=%b, want 0 1", ov8, ir8);
    end
  endtask

  task automatic test_stall();
    i8 = 8'b0010_0001; iv8 = 1'b1; ordy8 = 1'b0;
    tick();
    // A zero vector offered during SCAN must be ignored.
    i8 = 8'h00; iv8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (ov8 !== 1'b1 || y8 !== 3'd0 || last8 !== 1'b0 || zf8 !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: ov=%b y=%0d last=%b zf=%b, want 1 0 0 0", k, ov8, y8, last8, zf8);
      end
      tick();
    end
    iv8 = 1'b0;
    ordy8 = 1'b1;
    vectors++;
    if (y8 !== 3'd0 || zf8 !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: y=%0d zf=%b, want 0 0", y8, zf8);
    end
    tick();
    vectors++;
    if (ov8 !== 1'b1 || y8 !== 3'd5 || last8 !== 1'b1) begin
      errors++;
      $display("FAIL stall_second: ov=%b y=%0d last=%b, want 1 5 1", ov8, y8, last8);
    end
    tick();
    ordy8 = 1'b0;
    vectors++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL stall_end: ov=%b ir=%b, want 0 1", ov8, ir8);
    end
  endtask

  task automatic test_zero();
    i8 = 8'h00; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    vectors++;
    if (zf8 !== 1'b1 || ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL zero_pulse: zf=%b ov=%b ir=%b, want 1 0 1", zf8, ov8, ir8);
    end
`ifdef ENCODER_POPCOUNT_EN
    vectors++;
    if (cnt8 !== 4'd0) begin
      errors++;
      $display("FAIL zero_count: got %0d want 0", cnt8);
    end
`endif
    tick();
    vectors++;
    if (zf8 !== 1'b0 || ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL zero_after: zf=%b ov=%b ir=%b, want 0 0 1", zf8, ov8, ir8);
    end
  endtask

  task automatic test_reset_mid_scan();
    i8 = 8'hFF; iv8 = 1'b1; ordy8 = 1'b1;
    tick();
    iv8 = 1'b0; i8 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (ov8 !== 1'b1 || y8 !== 3'(k)) begin
        errors++;
        $display("FAIL rst_pre%0d: ov=%b y=%0d, want 1 %0d", k, ov8, y8, k);
      end
      if (k < 2) tick();
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || y8 !== 3'd0 || last8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: ov=%b ir=%b y=%0d last=%b, want 0 1 0 0", ov8, ir8, y8, last8);
    end
    tick();
    rst_n = 1'b1;
    i8 = 8'h80; iv8 = 1'b1;
    tick();
    iv8 = 1'b0; i8 = 8'h00;
    vectors++;
    if (ov8 !== 1'b1 || y8 !== 3'd7 || last8 !== 1'b1) begin
      errors++;
      $display("FAIL rst_new_beat: ov=%b y=%0d last=%b, want 1 7 1", ov8, y8, last8);
    end
    tick();
    ordy8 = 1'b0;
    vectors++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL rst_new_end: ov=%b ir=%b, want 0 1", ov8, ir8);
    end
  endtask

  task automatic test_wide16();
    i16 = 16'hFFFF; iv16 = 1'b1; ordy16 = 1'b1;
    tick();
    i16 = 16'h0000;
`ifdef ENCODER_POPCOUNT_EN
    vectors++;
    if (cnt16 !== 5'd16) begin
      errors++;
      $display("FAIL wide_count: got %0d want 16", cnt16);
    end
`endif
    for (int k = 0; k < 16; k++) begin
      // Pulse in_valid with a zero vector; it must not be captured during SCAN.
      iv16 = (k % 2 == 0);
      vectors++;
      if (ov16 !== 1'b1 || y16 !== 4'(k) || last16 !== (k == 15) || zf16 !== 1'b0) begin
        errors++;
        $display("FAIL wide_beat%0d: ov=%b y=%0d last=%b zf=%b, want 1 %0d %b 0", k, ov16, y16, last16, zf16, k, (k == 15));
      end
      tick();
    end
    iv16 = 1'b0; ordy16 = 1'b0;
    vectors++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1 || zf16 !== 1'b0) begin
      errors++;
      $display("FAIL wide_end: ov=%b ir=%b zf=%b, want 0 1 0", ov16, ir16, zf16);
    end
`ifdef ENCODER_POPCOUNT_EN
    vectors++;
    if (cnt16 !== 5'd16) begin
      errors++;
      $display("FAIL wide_count_hold: got %0d want 16", cnt16);
    end
`endif
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    i8 = 8'h00; iv8 = 1'b0; ordy8 = 1'b0;
    i16 = 16'h0000; iv16 = 1'b0; ordy16 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_zero();
    test_reset_mid_scan();
    test_wide16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
